usr_rotate_ctrl: RTL and testbench

//  Command sequencer for the 4-bit universal shift register (USR). Accepts LOAD/CLEAR/

---
 rtl/usr_rotate_ctrl.sv | 110 +++++++++++
 tb/tb_usr_rotate_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/usr_rotate_ctrl.sv
// rtl/usr_rotate_ctrl.sv - LOAD/CLEAR/ROTATE-N command sequencer driving a universal shift register
module usr_rotate_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             usr_clr,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_parin,
  input  logic [WIDTH-1:0] usr_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ROTR  = 2'b01;
  localparam logic [1:0] OP_ROTL  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] load_n;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  // LOAD and CLEAR take a single USR update; rotates take one update per step
  assign load_n = (cmd_op == OP_ROTR || cmd_op == OP_ROTL) ? cmd_count : CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          cnt_d   = load_n;
          state_d = (load_n == '0) ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    result    = usr_out;
    usr_clr   = clr;
    usr_sel   = 2'b00;
    usr_parin = '0;
    if (state_q == S_EXEC) begin
      // USR rotate modes act on parin, so rotates feed the current value back
      case (op_q)
        OP_LOAD: begin
          usr_sel   = 2'b11;
          usr_parin = data_q;
        end
        OP_ROTR: begin
          usr_sel   = 2'b01;
          usr_parin = usr_out;
        end
        OP_ROTL: begin
          usr_sel   = 2'b10;
          usr_parin = usr_out;
        end
        OP_CLEAR: usr_clr = 1'b1;
        default:  usr_sel = 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_rotate_ctrl.sv
// tb/tb_usr_rotate_ctrl.sv - scoreboard bench for usr_rotate_ctrl with a behavioural USR in the loop
module tb_usr_rotate_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             usr_clr;
  logic [1:0]       usr_sel;
  logic [WIDTH-1:0] usr_parin;
  logic [WIDTH-1:0] usr_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  usr_rotate_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .usr_clr(usr_clr), .usr_sel(usr_sel), .usr_parin(usr_parin),
    .usr_out(usr_out), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Universal shift register: synchronous clear, rotate modes act on parin
  logic [WIDTH-1:0] usr_q = '0;
  assign usr_out = usr_q;
  always @(posedge clk) begin
    if (usr_clr) usr_q <= '0;
    else begin
      case (usr_sel)
        2'b01:   usr_q <= {usr_parin[0], usr_parin[WIDTH-1:1]};
        2'b10:   usr_q <= {usr_parin[WIDTH-2:0], usr_parin[WIDTH-1]};
        2'b11:   usr_q <= usr_parin;
        default: usr_q <= usr_q;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] res;
    int               done_cyc;
  } exp_t;

  exp_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [1:0] sel_of(input logic [1:0] op);
    case (op)
      2'b00:   return 2'b11;
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Monitor: per-cycle EXEC drive checks and done/result scoreboard pops
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!clr) begin
        if (busy && cmd_ready) chk("ready_busy_excl", 1, 0);
        if (done) begin
          if (sb.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
            chk("sel_at_done", 32'(usr_sel), 0);
          end
        end else if (busy) begin
          if (sb.size() == 0) chk("exec_without_cmd", 1, 0);
          else begin
            e = sb[0];
            chk("exec_sel", 32'(usr_sel), 32'(sel_of(e.op)));
            chk("exec_clr", 32'(usr_clr), 32'(e.op == 2'b11));
            chk("exec_parin", 32'(usr_parin),
                32'(e.op == 2'b00 ? e.data : (e.op == 2'b11 ? '0 : usr_out)));
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data,
                      input int cnt, input logic [WIDTH-1:0] res, output int acc_cyc);
    exp_t e;
    int k;
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = CNT_W'(cnt);
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    n = (op == 2'b01 || op == 2'b10) ? cnt : 1;
    e.op = op; e.data = data; e.res = res; e.done_cyc = cyc + n;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(sb.size() == 0 && cmd_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    int a0, a1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_usr_sel", 32'(usr_sel), 0);
    chk("rst_usr_parin", 32'(usr_parin), 0);
    chk("rst_usr_clr", 32'(usr_clr), 1);
    @(negedge clk);
    chk("rst_usr_out", 32'(usr_out), 0);
    clr = 1'b0;

    send(2'b00, 4'b1011, 0, 4'b1011, a0); wait_idle();
    send(2'b01, 4'b0000, 1, 4'b1101, a0); wait_idle();
    send(2'b00, 4'b1011, 0, 4'b1011, a0); wait_idle();
    send(2'b10, 4'b0000, 3, 4'b1101, a0); wait_idle();
    send(2'b00, 4'b0110, 0, 4'b0110, a0); wait_idle();
    send(2'b01, 4'b0000, 0, 4'b0110, a0); wait_idle();
    send(2'b00, 4'b1001, 0, 4'b1001, a0); wait_idle();
    send(2'b10, 4'b0000, 4, 4'b1001, a0); wait_idle();
    send(2'b11, 4'b0000, 0, 4'b0000, a0); wait_idle();

    // LOAD held on cmd_valid during a rotate must wait for cmd_ready
    send(2'b00, 4'b0011, 0, 4'b0011, a0); wait_idle();
    send(2'b01, 4'b0000, 5, 4'b1001, a0);
    send(2'b00, 4'b1111, 0, 4'b1111, a1);
    chk("busy_hold_accept_cycle", 32'(a1), 32'(a0 + 7));
    wait_idle();

    // Asynchronous abort in the middle of ROTR 5
    send(2'b00, 4'b1010, 0, 4'b1010, a0); wait_idle();
    send(2'b01, 4'b0000, 5, 4'b0000, a0);
    @(posedge clk);
    @(posedge clk);
    #2;
    clr = 1'b1;
    sb.delete();
    #1;
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_usr_clr", 32'(usr_clr), 1);
    @(posedge clk);
    #1;
    chk("abort_usr_out", 32'(usr_out), 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_ready_after", 32'(cmd_ready), 1);
    chk("abort_usr_kept", 32'(usr_out), 0);
    send(2'b00, 4'b0101, 0, 4'b0101, a0); wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end

endmodule
